// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, funct3 encodings and state enums for the tohost unit
package csr_pkg;

  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RW   = 2'd1,
    OP_RS   = 2'd2,
    OP_RC   = 2'd3
  } csr_op_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } tohost_state_e;

  // Register and immediate forms share the low two bits; funct3 000/100 are not CSR ops.
  function automatic csr_op_e decode_op(input logic [2:0] f3);
    case (f3)
      F3_RW, F3_RWI: decode_op = OP_RW;
      F3_RS, F3_RSI: decode_op = OP_RS;
      F3_RC, F3_RCI: decode_op = OP_RC;
      default:       decode_op = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with synchronous clear
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [63:0] count
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_tohost_unit.sv
// rtl/csr_tohost_unit.sv - execute-stage CSR block: tohost status register plus cycle/instret
module csr_tohost_unit
  import csr_pkg::*;
#(
  parameter logic [11:0] TOHOST_ADDR     = CSR_TOHOST,
  parameter logic [31:0] RESET_TOHOST    = 32'h0,
  parameter bit          LOCK_ON_NONZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic        stall,
  input  logic        flush,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_zimm,
  input  logic        instr_retire,
  output logic [31:0] rd_data,
  output logic [31:0] tohost,
  output logic        halted,
  output logic        illegal
);

  logic [63:0]   cycle_cnt;
  logic [63:0]   instret_cnt;
  tohost_state_e state_q, state_d;
  logic [31:0]   tohost_q, tohost_d;
  csr_op_e       op;
  logic [31:0]   src, old_val, new_val;
  logic          accept, is_write, mapped, read_only, tohost_we;

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .count (instret_cnt)
  );

  always_comb begin
    old_val   = '0;
    mapped    = 1'b0;
    read_only = 1'b0;
    if (csr_addr == TOHOST_ADDR) begin
      old_val = tohost_q;
      mapped  = 1'b1;
    end else begin
      case (csr_addr)
        CSR_CYCLE:    begin old_val = cycle_cnt[31:0];    mapped = 1'b1; read_only = 1'b1; end
        CSR_CYCLEH:   begin old_val = cycle_cnt[63:32];   mapped = 1'b1; read_only = 1'b1; end
        CSR_INSTRET:  begin old_val = instret_cnt[31:0];  mapped = 1'b1; read_only = 1'b1; end
        CSR_INSTRETH: begin old_val = instret_cnt[63:32]; mapped = 1'b1; read_only = 1'b1; end
        default: ;
      endcase
    end
  end

  // Set/clear with a zero source field is a pure read and never writes.
  always_comb begin
    op       = decode_op(funct3);
    src      = funct3[2] ? {27'd0, rs1_zimm} : rs1_data;
    is_write = (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && (rs1_zimm != 5'd0));
    case (op)
      OP_RW:   new_val = src;
      OP_RS:   new_val = old_val | src;
      OP_RC:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign accept    = csr_en & ~stall & ~flush;
  assign illegal   = accept & (~mapped | (read_only & is_write));
  assign tohost_we = accept & is_write & ~illegal & (csr_addr == TOHOST_ADDR);
  assign rd_data   = csr_en ? old_val : '0;

  always_comb begin
    state_d  = state_q;
    tohost_d = tohost_q;
    case (state_q)
      RUN: begin
        if (tohost_we) begin
          tohost_d = new_val;
          if (new_val != 32'd0) state_d = DONE;
        end
      end
      DONE: begin
        if (tohost_we && !LOCK_ON_NONZERO) tohost_d = new_val;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      tohost_q <= RESET_TOHOST;
    end else begin
      state_q  <= state_d;
      tohost_q <= tohost_d;
    end
  end

  assign tohost = tohost_q;
  assign halted = (state_q == DONE);

endmodule

// File: tb/tb_csr_tohost_unit.sv
// tb/tb_csr_tohost_unit.sv - self-checking bench for csr_tohost_unit
module tb_csr_tohost_unit;

  logic        clk = 1'b0;
  logic        rst, csr_en, stall, flush, instr_retire;
  logic [11:0] csr_addr;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_zimm;
  logic [31:0] rd_data, tohost;
  logic        halted, illegal;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_tohost;
  logic        m_halted;
  logic [63:0] m_cycle, m_instret;
  bit          m_valid = 1'b0;

  csr_tohost_unit dut (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (csr_en),
    .stall        (stall),
    .flush        (flush),
    .csr_addr     (csr_addr),
    .funct3       (funct3),
    .rs1_data     (rs1_data),
    .rs1_zimm     (rs1_zimm),
    .instr_retire (instr_retire),
    .rd_data      (rd_data),
    .tohost       (tohost),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h51E: return m_tohost;
      12'hC00: return m_cycle[31:0];
      12'hC80: return m_cycle[63:32];
      12'hC02: return m_instret[31:0];
      12'hC82: return m_instret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_mapped(input logic [11:0] a);
    return a == 12'h51E || a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82;
  endfunction

  function automatic bit m_writes();
    if (funct3 == 3'b001 || funct3 == 3'b101) return 1'b1;
    if (funct3 == 3'b010 || funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
      return rs1_zimm != 5'd0;
    return 1'b0;
  endfunction

  function automatic bit m_illegal();
    if (!(csr_en && !stall && !flush)) return 1'b0;
    if (!m_mapped(csr_addr)) return 1'b1;
    return csr_addr != 12'h51E && m_writes();
  endfunction

  function automatic logic [31:0] m_new();
    logic [31:0] s, o;
    s = funct3[2] ? {27'd0, rs1_zimm} : rs1_data;
    o = m_read(csr_addr);
    case (funct3[1:0])
      2'b01:   return s;
      2'b10:   return o | s;
      2'b11:   return o & ~s;
      default: return o;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] nv;
    if (rst) begin
      m_tohost = 32'd0; m_halted = 1'b0; m_cycle = 64'd0; m_instret = 64'd0; m_valid = 1'b1;
    end else begin
      nv = m_new();
      if (csr_en && !stall && !flush && !m_illegal() && m_writes() && csr_addr == 12'h51E
          && !m_halted) begin
        m_tohost = nv;
        if (nv != 32'd0) m_halted = 1'b1;
      end
      m_cycle = m_cycle + 64'd1;
      if (instr_retire) m_instret = m_instret + 64'd1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tohost", tohost, m_tohost);
      chk("model_halted", halted, m_halted);
      if (csr_en) begin
        chk("model_rd_data", rd_data, m_read(csr_addr));
        chk("model_illegal", illegal, m_illegal());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] z);
    csr_en = 1'b1; funct3 = f3; csr_addr = a; rs1_data = d; rs1_zimm = z;
  endtask

  task automatic idle();
    csr_en = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_retire = 1'b0; idle(); set_op(3'b000, 12'h0, 32'h0, 5'h0); csr_en = 1'b0;

    // counters
    step(); step(); rst = 1'b0;
    set_op(3'b010, 12'hC00, 32'h0, 5'd0); #1;
    chk("cycle_first", rd_data, 32'd0);
    chk("reset_tohost", tohost, 32'd0);
    chk("reset_halted", halted, 1'b0);
    idle(); step();
    repeat (99) step();
    set_op(3'b010, 12'hC00, 32'h0, 5'd0); #1;
    chk("cycle_100", rd_data, 32'd100);
    step(); idle();
    dut.u_cycle.count_q = 64'hFFFF_FFFF;
    m_cycle = 64'hFFFF_FFFF;
    step(); step();
    set_op(3'b010, 12'hC80, 32'h0, 5'd0); #1;
    chk("cycleh_carry", rd_data, 32'd1);
    step(); idle(); instr_retire = 1'b1;
    repeat (5) step();
    instr_retire = 1'b0;
    set_op(3'b010, 12'hC02, 32'h0, 5'd0); #1;
    chk("instret_5", rd_data, 32'd5);
    chk("instret_read_legal", illegal, 1'b0);
    step(); set_op(3'b001, 12'hC02, 32'h55, 5'd1); #1;
    chk("ro_write_illegal", illegal, 1'b1);
    step(); set_op(3'b010, 12'hC02, 32'h0, 5'd0); #1;
    chk("instret_unchanged", rd_data, 32'd5);
    step(); set_op(3'b001, 12'h123, 32'h1, 5'd1); #1;
    chk("unmapped_illegal", illegal, 1'b1);
    chk("unmapped_rd", rd_data, 32'd0);
    step(); set_op(3'b001, 12'hC02, 32'h1, 5'd1); stall = 1'b1; flush = 1'b1; #1;
    chk("stall_flush_no_illegal", illegal, 1'b0);
    step(); idle();

    // tohost write and lock
    rst = 1'b1; step(); rst = 1'b0;
    set_op(3'b001, 12'h51E, 32'd0, 5'd1); #1;
    chk("wr0_rd", rd_data, 32'd0);
    step(); set_op(3'b001, 12'h51E, 32'd1, 5'd1); #1;
    chk("wr0_stays_run", halted, 1'b0);
    chk("wr1_rd_old", rd_data, 32'd0);
    step(); idle(); #1;
    chk("wr1_tohost", tohost, 32'd1);
    chk("wr1_halted", halted, 1'b1);
    set_op(3'b001, 12'h51E, 32'd7, 5'd1); #1;
    chk("wr7_rd", rd_data, 32'd1);
    step(); idle(); #1;
    chk("wr7_locked", tohost, 32'd1);

    // immediate set then clear
    rst = 1'b1; step(); rst = 1'b0;
    set_op(3'b110, 12'h51E, 32'h0, 5'd4); #1;
    chk("rsi_rd", rd_data, 32'd0);
    step(); set_op(3'b111, 12'h51E, 32'h0, 5'd4); #1;
    chk("rci_rd", rd_data, 32'd4);
    step(); idle(); #1;
    chk("rci_ignored", tohost, 32'd4);
    chk("rsi_halted", halted, 1'b1);

    // stall then flush, then release
    rst = 1'b1; step(); rst = 1'b0;
    set_op(3'b001, 12'h51E, 32'd3, 5'd1); stall = 1'b1;
    step(); stall = 1'b0; flush = 1'b1;
    step(); flush = 1'b0; #1;
    chk("stall_flush_tohost", tohost, 32'd0);
    step(); idle(); #1;
    chk("release_tohost", tohost, 32'd3);

    // write in the reset cycle is discarded
    rst = 1'b1; set_op(3'b001, 12'h51E, 32'd9, 5'd1);
    step(); rst = 1'b0;
    set_op(3'b010, 12'hC00, 32'h0, 5'd0); #1;
    chk("rst_wr_tohost", tohost, 32'd0);
    chk("rst_wr_halted", halted, 1'b0);
    chk("rst_wr_cycle", rd_data, 32'd0);
    step(); idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/csr_tohost_unit.md
Name: csr_tohost_unit

Overview:
- CPU-side CSR block that software writes to report test status.
- Holds the `tohost` CSR (0x51E) plus read-only 64-bit `cycle` and `instret` counters.
- Sits in the CPU execute stage; executes CSRRW/CSRRS/CSRRC and their immediate forms.
- Exposes `tohost` as a stable, hierarchically probeable register. Simulation benches poll it: 0 = running, 1 = pass, any other nonzero value = fail code.

Parameters:
- TOHOST_ADDR, 12'h51E, address of the tohost CSR.
- RESET_TOHOST, 32'h0, reset value of tohost.
- LOCK_ON_NONZERO, 1, when 1, the first nonzero tohost write is final.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- csr_en  in  1  execute-stage instruction is a CSR op
- stall  in  1  pipeline stall; request not accepted
- flush  in  1  instruction squashed; request not accepted
- csr_addr  in  12  CSR address from instr[31:20]
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- rs1_data  in  32  source operand for register forms
- rs1_zimm  in  5  instr[19:15]; zimm for immediate forms, x0 test for register forms
- instr_retire  in  1  one instruction retired this cycle
- rd_data  out  32  old CSR value, combinational
- tohost  out  32  current tohost register
- halted  out  1  tohost has been written nonzero (sticky)
- illegal  out  1  accepted op is illegal; valid in the same cycle

Behaviour:
- Accept condition: `accept = csr_en & ~stall & ~flush`.
- Read and write timing:
  - `rd_data` = pre-write value of the addressed CSR in the same cycle, whenever `csr_en` is high.
  - `rd_data` = 0 for unmapped addresses.
  - The write takes effect at the clk edge ending the accept cycle.
  - A CSR op in the next cycle reads the new value (no forwarding needed).
- Source operand `src`:
  - Register forms: `rs1_data`.
  - Immediate forms: zero-extended `rs1_zimm`.
- New value:
  - RW: `src`.
  - RS: `old | src`.
  - RC: `old & ~src`.
- Write suppression: RS/RC/RSI/RCI with `rs1_zimm == 0` perform no write and are never illegal.
- `illegal` asserts (combinationally, on accept) for:
  - unmapped `csr_addr`;
  - a writing op to a read-only CSR (0xC00, 0xC02, 0xC80, 0xC82).
  - An illegal op causes no state change.
- CSR map:
  - 0xC00: `cycle[31:0]`; 0xC80: `cycle[63:32]`.
  - 0xC02: `instret[31:0]`; 0xC82: `instret[63:32]`.
  - `TOHOST_ADDR`: RW.
- Counters:
  - `cycle` increments every clk with rst low; it reads 0 in the first cycle after rst deasserts.
  - `instret` increments on `instr_retire`.
  - Both are 64-bit and wrap from all-ones to 0 silently.
  - Counter reads return the value before this cycle's increment.
- tohost FSM, states RUN and DONE:
  - Reset → RUN, `tohost = RESET_TOHOST`, `halted = 0`.
  - RUN: an accepted write of nonzero `new` → DONE, `tohost = new`, `halted = 1`.
  - RUN: a write of 0 stays in RUN with `tohost = 0`.
  - DONE with `LOCK_ON_NONZERO = 1`: further writes are ignored; `rd_data` still returns the locked value.
  - DONE with `LOCK_ON_NONZERO = 0`: writes update `tohost`; `halted` stays 1 until reset.
- Reset mid-operation: rst dominates accept, so a write in the rst cycle is discarded. All outputs return to reset values at the next edge, and both counters go to 0.
- Simultaneous stall and flush: no accept, no write, `illegal = 0`.

Decomposition:
- Package `csr_pkg`:
  - CSR address constants (TOHOST, CYCLE, CYCLEH, INSTRET, INSTRETH).
  - funct3 encodings and a `csr_op_e` enum.
  - A `tohost_state_e` enum {RUN, DONE}.
- One sub-module, `csr_counter64`:
  - Ports: clk, rst, inc, 64-bit count.
  - Instantiated twice, once for `cycle` and once for `instret`.

Test Plan:
- Reset, then CSRRW 0x51E with `rs1_data = 1` → `rd_data = 0` in the accept cycle; `tohost = 1` and `halted = 1` the next cycle; a following CSRRW with 7 leaves `tohost = 1`.
- CSRRSI 0x51E with zimm 4, then CSRRCI with zimm 4 → `tohost` goes 0 → 4 (DONE, locked); the clear is ignored; `rd_data = 4` on the second op.
- CSRRS 0xC00 at 100 cycles after rst deassert → `rd_data = 100`. Force `cycle = 64'hFFFF_FFFF` and read 0xC80 two cycles later → 1.
- Pulse `instr_retire` 5 times, then CSRRS 0xC02 with `rs1_zimm = 0` → `rd_data = 5`, `illegal = 0`. CSRRW 0xC02 → `illegal = 1`, `instret` unchanged.
- CSRRW 0x51E with value 3 while `stall = 1`, then `flush = 1` → `tohost` stays 0. Release both → `tohost = 3`.
- CSRRW 0x51E with 9 in the same cycle as rst = 1 → `tohost = 0`, `halted = 0`, `cycle = 0` after the edge.
